// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// ps2_pkg : frame constants, FSM encoding and parity helper for ps2_rx
// Revision: 1.0
// ============================================================================
package ps2_pkg;

  localparam int PS2_FRAME_BITS         = 11;
  localparam int DEFAULT_DEPTH          = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 50000;

  localparam int                 STATE_W  = 1;
  localparam logic [STATE_W-1:0] ST_IDLE  = 1'b0;
  localparam logic [STATE_W-1:0] ST_SHIFT = 1'b1;

  // Counter value on the edge that carries the stop bit
  localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_fifo.sv
`default_nettype none
// ============================================================================
// ps2_fifo : first-word-fall-through scan-code FIFO, pointer MSB marks wrap
// Revision: 1.0
// ============================================================================
module ps2_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        wr_en;
  logic        rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // A pop in the same cycle frees the slot that the push overwrites
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
// ps2_rx : PS/2 device-to-host frame receiver feeding a scan-code FIFO
// Revision: 1.0
// ============================================================================
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int DEPTH          = DEFAULT_DEPTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rdn,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  logic [2:0]         clk_sync_q, clk_sync_d;
  logic [2:0]         dat_sync_q, dat_sync_d;
  logic               rdn_q, rdn_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [9:0]         shreg_q, shreg_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               overflow_q, overflow_d;
  logic               frame_err_q, frame_err_d;

  logic w_fall;
  logic w_bit_in;
  logic w_frame_done;
  logic w_frame_ok;
  logic w_pop;
  logic w_push;
  logic w_fifo_full;
  logic w_fifo_empty;

  assign w_fall   = (clk_sync_q[2:1] == 2'b10);
  assign w_bit_in = dat_sync_q[2];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_q  <= '1;
      dat_sync_q  <= '1;
      rdn_q       <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      to_cnt_q    <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      dat_sync_q  <= dat_sync_d;
      rdn_q       <= rdn_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      to_cnt_q    <= to_cnt_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Bits shift in from the top so start lands in [0], parity in [9]
  always_comb begin
    clk_sync_d = {clk_sync_q[1:0], ps2_clk};
    dat_sync_d = {dat_sync_q[1:0], ps2_data};
    rdn_d      = rdn;
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    to_cnt_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (w_fall) begin
          shreg_d   = {w_bit_in, shreg_q[9:1]};
          bit_cnt_d = 4'd1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_fall) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            shreg_d   = {w_bit_in, shreg_q[9:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (to_cnt_q == TO_LAST) begin
          bit_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_ONE;
        end
      end
      default: begin
        bit_cnt_d = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_frame_done = (state_q == ST_SHIFT) && w_fall && (bit_cnt_q == LAST_BIT);
    w_frame_ok   = w_frame_done && !shreg_q[0] && w_bit_in &&
                   odd_parity_ok(shreg_q[8:1], shreg_q[9]);
    w_pop        = rdn_q && !rdn && !w_fifo_empty;
    w_push       = w_frame_ok && (!w_fifo_full || w_pop);
    frame_err_d  = w_frame_done && !w_frame_ok;
    overflow_d   = overflow_q;
    if (w_pop) overflow_d = 1'b0;
    if (w_frame_ok && w_fifo_full && !w_pop) overflow_d = 1'b1;
  end

  ps2_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .push  (w_push),
    .din   (shreg_q[8:1]),
    .pop   (w_pop),
    .dout  (data),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  assign ready     = !w_fifo_empty;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx.sv
`default_nettype none
// ============================================================================
// tb_ps2_rx : scoreboard bench for ps2_rx, directed PS/2 frames and reads
// Revision: 1.0
// ============================================================================
module tb_ps2_rx;

  localparam int DEPTH = 8;
  localparam int TMO   = 300;
  localparam int HALF  = 20;

  logic       clk      = 1'b0;
  logic       clrn     = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rdn      = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  int         n_checks = 0;
  int         n_errors = 0;
  int         err_exp  = 0;
  int         err_seen = 0;
  int         ferr_len = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  logic       prev_rdn  = 1'b1;
  bit         chk_ready = 1'b0;

  always #5 clk = ~clk;

  ps2_rx #(
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rdn       (rdn),
    .data      (data),
    .ready     (ready),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit pop_at_stop);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      tick(HALF / 2);
      ps2_clk = 1'b0;
      if (pop_at_stop && i == 10) begin
        // rdn falls in the very cycle the synchronised stop edge is seen
        tick(2);
        rdn = 1'b0;
        tick(HALF - 2);
      end else begin
        tick(HALF);
      end
      ps2_clk = 1'b1;
      rdn     = 1'b1;
      tick(HALF / 2);
    end
  endtask

  // kind: 0 good, 1 bad parity, 2 bad stop
  task automatic send_frame(input logic [7:0] d, input int kind, input bit queued, input bit pop_at_stop);
    logic p;
    logic stop;
    p    = ~^d;
    stop = 1'b1;
    if (kind == 1) p = ~p;
    if (kind == 2) stop = 1'b0;
    if (kind == 0 && queued) exp_q.push_back(d);
    if (kind != 0) err_exp++;
    send_bits({stop, p, d, 1'b0}, 11, pop_at_stop);
    ps2_data = 1'b1;
    tick(HALF);
    check("frame_err_count", err_seen, err_exp);
  endtask

  task automatic do_pop(input int hold);
    rdn = 1'b0;
    tick(hold);
    rdn = 1'b1;
    tick(2);
  endtask

  // Monitor: every read strobe edge consumes one scoreboard entry
  initial begin
    forever begin
      @(negedge clk);
      if (!clrn) begin
        prev_rdn  = 1'b1;
        chk_ready = 1'b0;
        ferr_len  = 0;
      end else begin
        if (chk_ready) begin
          check("ready_after_pop", ready, exp_q.size() != 0);
          chk_ready = 1'b0;
        end
        if (prev_rdn && !rdn) begin
          if (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            check("pop_ready", ready, 1);
            check("pop_data", data, exp_b);
            chk_ready = 1'b1;
          end else begin
            check("empty_pop_ready", ready, 0);
          end
        end
        prev_rdn = rdn;
        if (frame_err) begin
          if (ferr_len == 0) err_seen++;
          ferr_len++;
        end else if (ferr_len != 0) begin
          check("frame_err_width", ferr_len, 1);
          ferr_len = 0;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(3);
    check("rst_ready", ready, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_err", frame_err, 0);
    clrn = 1'b1;
    tick(5);

    // Single frame
    send_frame(8'h1C, 0, 1, 0);
    check("single_ready", ready, 1);
    check("single_data", data, 8'h1C);
    do_pop(1);
    check("single_drained", ready, 0);

    // Two-frame sequence, then a read on empty
    send_frame(8'hF0, 0, 1, 0);
    send_frame(8'h1C, 0, 1, 0);
    do_pop(1);
    do_pop(1);
    do_pop(1);

    // Bad parity, good frame, bad stop
    send_frame(8'h1C, 1, 0, 0);
    check("bad_parity_ready", ready, 0);
    send_frame(8'h5A, 0, 1, 0);
    send_frame(8'h33, 2, 0, 0);
    check("bad_stop_overflow", overflow, 0);
    do_pop(1);
    check("bad_drained", ready, 0);

    // Overflow: ninth frame is dropped
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, i <= 8, 0);
    check("ovf_set", overflow, 1);
    check("ovf_ready", ready, 1);
    do_pop(1);
    check("ovf_cleared", overflow, 0);
    for (int i = 0; i < 7; i++) do_pop(1);
    do_pop(1);
    check("ovf_drained", ready, 0);

    // Long rdn low pops once
    send_frame(8'h21, 0, 1, 0);
    send_frame(8'h22, 0, 1, 0);
    do_pop(10);
    check("hold_one_left", ready, 1);
    do_pop(1);
    do_pop(1);

    // Empty pop must not disturb pointers
    do_pop(1);
    send_frame(8'h44, 0, 1, 0);
    do_pop(1);
    check("after_empty_pop", ready, 0);

    // Push and pop in the same cycle while full
    for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 0, 1, 0);
    check("full_no_ovf", overflow, 0);
    send_frame(8'h19, 0, 1, 1);
    check("simul_no_ovf", overflow, 0);
    check("simul_ready", ready, 1);
    for (int i = 0; i < 8; i++) do_pop(1);
    do_pop(1);
    check("simul_drained", ready, 0);

    // Timeout discards a partial frame silently
    send_bits(11'h7FE, 5, 0);
    ps2_data = 1'b1;
    tick(TMO + 100);
    send_frame(8'h5A, 0, 1, 0);
    do_pop(1);
    check("timeout_drained", ready, 0);

    // Reset mid-frame with data queued
    send_frame(8'h1C, 0, 1, 0);
    send_bits(11'h7FE, 5, 0);
    clrn = 1'b0;
    tick(3);
    check("midrst_ready", ready, 0);
    check("midrst_overflow", overflow, 0);
    exp_q.delete();
    clrn = 1'b1;
    tick(5);
    check("postrst_ready", ready, 0);
    send_frame(8'h5A, 0, 1, 0);
    do_pop(1);
    check("postrst_drained", ready, 0);

    tick(10);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_rx.md
# ps2_rx

PS/2 keyboard receiver with a receive FIFO. It samples the raw PS2_clk/PS2_Data pins, deserialises 11-bit device-to-host frames, checks them, and queues good scan codes in a first-word-fall-through FIFO. It sits directly upstream of the CPU-facing PS/2 I/O port, which pops scan codes with an active-low read strobe.

## Interface
- DEPTH, 8: FIFO entries; power of two, at least 2.
- TIMEOUT_CYCLES, 50000: idle clk cycles inside a frame before the receiver resynchronises (2 ms at 25 MHz).
- clk  in  1  single clock; every flop in the block is clocked by clk.
- clrn  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock pin; asynchronous to clk.
- ps2_data  in  1  raw PS/2 data pin; asynchronous to clk.
- rdn  in  1  active-low read strobe, synchronous to clk; a high-to-low transition pops one entry.
- data  out  8  scan code at the FIFO head; valid while ready=1.
- ready  out  1  FIFO not empty.
- overflow  out  1  sticky flag: a good frame was dropped because the FIFO was full.
- frame_err  out  1  one-cycle pulse when a completed frame fails a check.

## Operation
- Synchroniser: ps2_clk and ps2_data each pass through 3 flops. A falling edge is the synchronised clock pair equal to 2'b10. Data is sampled on that cycle.
- Frame: 11 bits, LSB first: start (0), d[7:0], parity (odd over d plus the parity bit), stop (1). A 4-bit counter runs 0..10.
- Receiver states:
  - IDLE: counter=0.
  - SHIFT: counter 1..10.
  - On the edge that captures bit 10 (the stop bit), the frame is checked and the counter returns to 0.
- Check: start==0, stop==1, and the XOR of d and the parity bit equals 1.
  - Pass: push d to the FIFO.
  - Fail: pulse frame_err and discard the frame; FIFO and overflow are unchanged.
- Timeout: in SHIFT, a counter increments each clk cycle with no falling edge.
  - On reaching TIMEOUT_CYCLES, the bit counter clears and the partial frame is discarded silently (no frame_err).
  - The timeout counter clears on every falling edge and in IDLE.
- FIFO:
  - Read and write pointers are log2(DEPTH)+1 bits wide; wrap is natural binary.
  - data = mem[rd_ptr[low bits]], combinational.
  - ready = (wr_ptr != rd_ptr).
  - Full = low bits equal and MSBs differ.
- Pop: rdn_q is a register of rdn, reset to 1. A pop occurs when rdn_q==1, rdn==0 and ready==1. Holding rdn low pops exactly once. A pop while empty is ignored.
- Overflow:
  - Set when a good frame completes, the FIFO is full, and no pop occurs in the same cycle. The frame is dropped.
  - Cleared by the next successful pop.
  - If a set and a clear coincide, set wins.
- Push and pop in the same cycle: the pop is evaluated first, so a full FIFO accepts the push. Occupancy is unchanged and overflow is not set.

## Timing
- Reset values:
  - data=mem[0] (FIFO memory is not reset; data is don't-care while ready=0); ready=0; overflow=0; frame_err=0.
  - Pointers=0, counters=0, synchroniser flops=1, rdn_q=1.
- Pin to edge detect: a falling edge on ps2_clk is recognised in the 3rd or 4th clk cycle after the pin transition.
- Stop-bit edge in cycle F:
  - Good frame: the push registers at the end of F, so ready=1 and data valid from F+1.
  - Bad frame: frame_err=1 for exactly cycle F+1.
- Pop: an rdn falling edge sampled in cycle P advances rd_ptr at the end of P. The new head (or ready=0) is visible in P+1.
- clrn asserted mid-frame or mid-read: all state clears immediately. The first frame after clrn deasserts must start on a fresh start bit.

## Structure
- Package ps2_pkg holds:
  - PS2_FRAME_BITS=11.
  - Default DEPTH and TIMEOUT_CYCLES.
  - A function for odd-parity check.
- Sub-module ps2_fifo: synchronous FWFT FIFO with push, pop, full, empty and dout, parameterised by DEPTH. The top level holds the synchroniser, the frame FSM, the timeout counter and the overflow logic.

## Test plan
- Single frame: send 0x1C with parity=0 (bit period 80 µs) -> ready=1, data=0x1C; pulse rdn low -> ready=0 one cycle later.
- Sequence: send 0xF0 (parity=1) then 0x1C -> data reads 0xF0, then 0x1C, then ready=0; frame_err never asserts.
- Bad parity: send 0x1C with parity=1 -> frame_err pulses for 1 cycle, ready stays 0. A following good 0x5A (parity=1) -> data=0x5A.
- Overflow: send 9 good frames 0x01..0x09 without reading -> overflow=1, ready=1. Pops return 0x01..0x08, and overflow clears after the first pop.
- Timeout and reset:
  - Send 5 bits, idle longer than TIMEOUT_CYCLES, then send a full 0x5A -> only 0x5A is queued, with no frame_err.
  - Repeat with clrn pulsed low mid-frame instead of idling -> same result.
- Read strobe: hold rdn low for 10 cycles with 2 entries queued -> exactly one pop. A pop on an empty FIFO -> no pointer change. Push and pop in the same cycle while full -> occupancy stays at 8, overflow stays 0.
